// File: rtl/fpu_mul_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fpu_mul_arbiter_pkg
//   Shared types and constants for the fpuMul16 sharing arbiter.
//   - fp16_t        : IEEE-754 binary16 bit pattern
//   - condCode_t    : multiplier condition codes
//   - statusFlag_t  : multiplier status flags
//   - arbState_t    : arbiter FSM encoding
//   - FP16_QNAN     : quiet NaN returned when an operation is aborted
// ---------------------------------------------------------------------------
package fpu_mul_arbiter_pkg;

  typedef logic [15:0] fp16_t;
  typedef logic [3:0]  condCode_t;
  typedef logic [4:0]  statusFlag_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arbState_t;

  localparam fp16_t FP16_QNAN = 16'h7E00;

endpackage

// File: rtl/fpu_mul_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// fpu_rr_pick
//   Combinational round-robin priority picker. Searches req_i starting at
//   ptr_i and wrapping modulo NUM_REQ; the first set bit wins.
// Ports
//   req_i  in  NUM_REQ  request vector
//   ptr_i  in  IDW      index with highest priority this cycle
//   gnt_o  out NUM_REQ  one-hot grant (all zero when no request)
//   idx_o  out IDW      index of the granted bit
//   any_o  out 1        at least one request present
// ---------------------------------------------------------------------------
module fpu_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);

  // Rotating priority search; the any_o guard keeps the grant one-hot.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int cand;
      cand = (int'(ptr_i) + i) % NUM_REQ;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_mul_arbiter
//   Shares a single fpuMul16 among NUM_REQ requesters. One operation is in
//   flight at a time: IDLE (grant) -> ISSUE (start pulse) -> WAIT (done or
//   watchdog abort) -> RESP (valid/ready hand-off) -> IDLE.
// Ports
//   clock, reset                 clock, synchronous active-high reset
//   reqValid/reqIn1/reqIn2       per-lane request and operands
//   reqReady                     one-hot accept, combinational, IDLE only
//   respValid/respReady          response handshake
//   respId/respOut/respCondCodes/respStatusFlags/respErr  response payload
//   busy                         FSM not in IDLE
//   mulIn1/mulIn2/mulStart       to the shared multiplier
//   mulDone/mulOut/mulCondCodes/mulStatusFlags  from the shared multiplier
// ---------------------------------------------------------------------------
module fpu_mul_arbiter
  import fpu_mul_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 64,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        reqValid,
  input  fp16_t [NUM_REQ-1:0]       reqIn1,
  input  fp16_t [NUM_REQ-1:0]       reqIn2,
  output logic [NUM_REQ-1:0]        reqReady,
  output logic                      respValid,
  input  logic                      respReady,
  output logic [IDW-1:0]            respId,
  output fp16_t                     respOut,
  output condCode_t                 respCondCodes,
  output statusFlag_t               respStatusFlags,
  output logic                      respErr,
  output logic                      busy,
  output fp16_t                     mulIn1,
  output fp16_t                     mulIn2,
  output logic                      mulStart,
  input  logic                      mulDone,
  input  fp16_t                     mulOut,
  input  condCode_t                 mulCondCodes,
  input  statusFlag_t               mulStatusFlags
);

  localparam int             WDW     = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  arbState_t         state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  fp16_t             op_a_q, op_a_d;
  fp16_t             op_b_q, op_b_d;
  logic [WDW-1:0]    wdog_q, wdog_d;
  fp16_t             res_q, res_d;
  condCode_t         cc_q, cc_d;
  statusFlag_t       sf_q, sf_d;
  logic              err_q, err_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;

  fpu_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req_i (reqValid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) state_d = ARB_ISSUE;
        else          state_d = ARB_IDLE;
      end
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (mulDone || (wdog_q == WD_LAST)) state_d = ARB_RESP;
        else                                state_d = ARB_WAIT;
      end
      ARB_RESP: begin
        if (respReady) state_d = ARB_IDLE;
        else           state_d = ARB_RESP;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Datapath next-state: operand/id capture at grant, result capture or
  // abort in WAIT. Done takes priority over a coincident watchdog expiry.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    wdog_d   = wdog_q;
    res_d    = res_q;
    cc_d     = cc_q;
    sf_d     = sf_q;
    err_d    = err_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          id_d   = pick_idx;
          op_a_d = reqIn1[pick_idx];
          op_b_d = reqIn2[pick_idx];
          if (pick_idx == IDW'(NUM_REQ - 1)) rr_ptr_d = '0;
          else                               rr_ptr_d = pick_idx + IDW'(1);
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end
      ARB_ISSUE: wdog_d = '0;
      ARB_WAIT: begin
        if (mulDone) begin
          res_d = mulOut;
          cc_d  = mulCondCodes;
          sf_d  = mulStatusFlags;
          err_d = 1'b0;
        end else if (wdog_q == WD_LAST) begin
          res_d = FP16_QNAN;
          cc_d  = '0;
          sf_d  = '0;
          err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      ARB_RESP: err_d = err_q;
      default:  err_d = err_q;
    endcase
  end

  // Datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      wdog_q   <= '0;
      res_q    <= '0;
      cc_q     <= '0;
      sf_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      wdog_q   <= wdog_d;
      res_q    <= res_d;
      cc_q     <= cc_d;
      sf_q     <= sf_d;
      err_q    <= err_d;
    end
  end

  // FSM outputs. reqReady is also masked by reset so no lane sees an
  // accept while the block is being reset.
  always_comb begin
    reqReady  = '0;
    mulStart  = 1'b0;
    respValid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ARB_IDLE: begin
        busy = 1'b0;
        if (!reset) reqReady = pick_gnt;
        else        reqReady = '0;
      end
      ARB_ISSUE: mulStart  = 1'b1;
      ARB_WAIT:  busy      = 1'b1;
      ARB_RESP:  respValid = 1'b1;
      default:   busy      = 1'b1;
    endcase
  end

  assign mulIn1          = op_a_q;
  assign mulIn2          = op_b_q;
  assign respId          = id_q;
  assign respOut         = res_q;
  assign respCondCodes   = cc_q;
  assign respStatusFlags = sf_q;
  assign respErr         = err_q;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_mul_arbiter
//   Directed bench for fpu_mul_arbiter. A behavioural multiplier with fixed
//   latency answers from a table of hand-computed fp16 products; it can be
//   switched into a dead state that never raises done.
// ---------------------------------------------------------------------------
module tb_fpu_mul_arbiter;
  import fpu_mul_arbiter_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 64;
  localparam int IDW     = 2;
  localparam int MUL_LAT = 2;

  logic               clock = 1'b0;
  logic               reset;
  logic [NUM_REQ-1:0] reqValid;
  fp16_t [NUM_REQ-1:0] reqIn1;
  fp16_t [NUM_REQ-1:0] reqIn2;
  logic [NUM_REQ-1:0] reqReady;
  logic               respValid;
  logic               respReady;
  logic [IDW-1:0]     respId;
  fp16_t              respOut;
  condCode_t          respCondCodes;
  statusFlag_t        respStatusFlags;
  logic               respErr;
  logic               busy;
  fp16_t              mulIn1, mulIn2;
  logic               mulStart;
  logic               mulDone;
  fp16_t              mulOut;
  condCode_t          mulCondCodes;
  statusFlag_t        mulStatusFlags;

  always #5 clock = ~clock;

  fpu_mul_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqIn1(reqIn1), .reqIn2(reqIn2), .reqReady(reqReady),
    .respValid(respValid), .respReady(respReady), .respId(respId),
    .respOut(respOut), .respCondCodes(respCondCodes),
    .respStatusFlags(respStatusFlags), .respErr(respErr), .busy(busy),
    .mulIn1(mulIn1), .mulIn2(mulIn2), .mulStart(mulStart), .mulDone(mulDone),
    .mulOut(mulOut), .mulCondCodes(mulCondCodes), .mulStatusFlags(mulStatusFlags)
  );

  // Table of products worked out by hand.
  function automatic fp16_t model_prod(input fp16_t a, input fp16_t b);
    case ({a, b})
      32'h3C00_3C00: return 16'h3C00;  // 1.0 * 1.0
      32'h4A00_4880: return 16'h56C0;  // 12 * 9 = 108
      32'hCB00_5770: return 16'hE682;  // -14 * 119 = -1666
      32'h4B48_47D5: return 16'h5721;  // 14.5625 * 7.83203125 -> 114.0625
      default:       return 16'h0000;
    endcase
  endfunction

  function automatic condCode_t model_cc(input fp16_t p);
    return {p[15], (p[14:0] == 15'd0), 2'b01};
  endfunction

  function automatic statusFlag_t model_sf(input fp16_t a, input fp16_t b);
    return ({a, b} == 32'h4B48_47D5) ? 5'b00001 : 5'b00000;  // inexact case
  endfunction

  // Behavioural multiplier: done MUL_LAT cycles after start unless dead.
  int    mul_cnt;
  fp16_t mul_a, mul_b;
  bit    stub_dead;
  always @(posedge clock) begin
    if (reset) begin
      mul_cnt        <= 0;
      mulDone        <= 1'b0;
      mulOut         <= 16'h0000;
      mulCondCodes   <= 4'h0;
      mulStatusFlags <= 5'h00;
    end else begin
      mulDone <= 1'b0;
      if (mulStart) begin
        mul_cnt <= MUL_LAT;
        mul_a   <= mulIn1;
        mul_b   <= mulIn2;
      end else if (mul_cnt != 0) begin
        mul_cnt <= mul_cnt - 1;
        if (mul_cnt == 1 && !stub_dead) begin
          mulDone        <= 1'b1;
          mulOut         <= model_prod(mul_a, mul_b);
          mulCondCodes   <= model_cc(model_prod(mul_a, mul_b));
          mulStatusFlags <= model_sf(mul_a, mul_b);
        end
      end
    end
  end

  typedef struct {
    int          id;
    fp16_t       out;
    condCode_t   cc;
    statusFlag_t sf;
    bit          err;
    int          cyc;
  } resp_t;

  resp_t resp_q[$];
  int    grant_q[$];
  int    gcyc_q[$];
  int    start_q[$];
  int    rise_q[$];
  int    bad_gnt;
  int    cyc;
  int    checks;
  int    failures;
  logic [NUM_REQ-1:0] prev_gnt;
  logic  prev_rv;
  bit    keep_req;

  // One clock: observe at negedge, advance, then retire granted requests.
  task automatic step();
    logic [NUM_REQ-1:0] g;
    resp_t r;
    @(negedge clock);
    g = reqReady;
    if (g != '0) begin
      for (int i = 0; i < NUM_REQ; i++) if (g[i]) grant_q.push_back(i);
      gcyc_q.push_back(cyc);
    end
    if ($countones(g) > 1 || (g != '0 && busy) || (g != '0 && prev_gnt != '0)) bad_gnt++;
    prev_gnt = g;
    if (mulStart) start_q.push_back(cyc);
    if (respValid && !prev_rv) rise_q.push_back(cyc);
    prev_rv = respValid;
    if (respValid && respReady) begin
      r.id = int'(respId); r.out = respOut; r.cc = respCondCodes;
      r.sf = respStatusFlags; r.err = respErr; r.cyc = cyc;
      resp_q.push_back(r);
    end
    @(posedge clock);
    cyc++;
    #1;
    if (!keep_req) reqValid = reqValid & ~g;
  endtask

  task automatic clear_logs();
    resp_q.delete(); grant_q.delete(); gcyc_q.delete();
    start_q.delete(); rise_q.delete();
  endtask

  // Clock until n responses are logged; on timeout pad with bogus entries
  // so the following comparisons report the miss.
  task automatic wait_resps(input int n, input int budget, input string name);
    resp_t dummy;
    int k;
    k = 0;
    while (resp_q.size() < n && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (resp_q.size() < n) begin
      failures++;
      $display("FAIL %s_timeout got=%0d responses exp=%0d", name, resp_q.size(), n);
      dummy.id = -1; dummy.out = 16'hDEAD; dummy.cc = 4'hF; dummy.sf = 5'h1F;
      dummy.err = 1'b1; dummy.cyc = -1;
      while (resp_q.size() < n) resp_q.push_back(dummy);
    end
    while (grant_q.size() < n) begin grant_q.push_back(-1); gcyc_q.push_back(-1); end
    while (start_q.size() < n) start_q.push_back(-1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    reqValid = '0;
    step(); step();
    reset = 1'b0;
    prev_gnt = '0;
    clear_logs();
  endtask

  task automatic test_reset();
    reset = 1'b1; reqValid = 4'b1111; respReady = 1'b1; keep_req = 1'b1;
    reqIn1 = {4{16'h3C00}}; reqIn2 = {4{16'h3C00}};
    step(); step(); step();
    checks++; if (reqReady !== 4'b0000) begin failures++; $display("FAIL rst_reqReady got=%b exp=0000", reqReady); end
    checks++; if (respValid !== 1'b0) begin failures++; $display("FAIL rst_respValid got=%b exp=0", respValid); end
    checks++; if (mulStart !== 1'b0) begin failures++; $display("FAIL rst_mulStart got=%b exp=0", mulStart); end
    checks++; if (mulIn1 !== 16'h0000 || mulIn2 !== 16'h0000) begin failures++; $display("FAIL rst_mulIn got=%h/%h exp=0000/0000", mulIn1, mulIn2); end
    checks++; if (respErr !== 1'b0) begin failures++; $display("FAIL rst_respErr got=%b exp=0", respErr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (respOut !== 16'h0000 || respId !== 2'd0) begin failures++; $display("FAIL rst_resp got=%h id=%0d exp=0000 id=0", respOut, respId); end
    keep_req = 1'b0;
    pulse_reset();
  endtask

  task automatic test_single();
    clear_logs();
    reqIn1[0] = 16'h3C00; reqIn2[0] = 16'h3C00; reqValid = 4'b0001;
    wait_resps(1, 40, "single");
    repeat (3) step();
    checks++; if (start_q.size() != 1) begin failures++; $display("FAIL single_starts got=%0d exp=1", start_q.size()); end
    checks++; if (start_q[0] - gcyc_q[0] != 1) begin failures++; $display("FAIL single_grant_to_start got=%0d exp=1", start_q[0] - gcyc_q[0]); end
    checks++; if (rise_q.size() < 1 || rise_q[0] - start_q[0] != MUL_LAT + 2) begin failures++; $display("FAIL single_start_to_valid got=%0d exp=%0d", (rise_q.size() < 1) ? -1 : rise_q[0] - start_q[0], MUL_LAT + 2); end
    checks++; if (resp_q[0].id != 0 || resp_q[0].out !== 16'h3C00) begin failures++; $display("FAIL single_result got=id%0d %h exp=id0 3C00", resp_q[0].id, resp_q[0].out); end
    checks++; if (resp_q[0].err !== 1'b0 || resp_q[0].cc !== 4'b0001 || resp_q[0].sf !== 5'b00000) begin failures++; $display("FAIL single_flags got=err%b cc%b sf%b exp=err0 cc0001 sf00000", resp_q[0].err, resp_q[0].cc, resp_q[0].sf); end
  endtask

  task automatic test_two_lanes();
    pulse_reset();
    reqIn1[0] = 16'h4A00; reqIn2[0] = 16'h4880;
    reqIn1[1] = 16'hCB00; reqIn2[1] = 16'h5770;
    reqValid = 4'b0011;
    wait_resps(2, 60, "two");
    checks++; if (resp_q[0].id != 0 || resp_q[0].out !== 16'h56C0) begin failures++; $display("FAIL two_first got=id%0d %h exp=id0 56C0", resp_q[0].id, resp_q[0].out); end
    checks++; if (resp_q[1].id != 1 || resp_q[1].out !== 16'hE682) begin failures++; $display("FAIL two_second got=id%0d %h exp=id1 E682", resp_q[1].id, resp_q[1].out); end
    // Pointer should now be 2: of lanes 1 and 3, lane 3 wins first.
    step();
    clear_logs();
    reqIn1[1] = 16'h3C00; reqIn2[1] = 16'h3C00;
    reqIn1[3] = 16'h3C00; reqIn2[3] = 16'h3C00;
    reqValid = 4'b1010;
    wait_resps(2, 60, "ptr");
    checks++; if (grant_q[0] != 3 || grant_q[1] != 1) begin failures++; $display("FAIL ptr_order got=%0d,%0d exp=3,1", grant_q[0], grant_q[1]); end
  endtask

  task automatic test_fairness();
    int k;
    pulse_reset();
    reqIn1 = {4{16'h3C00}}; reqIn2 = {4{16'h3C00}};
    bad_gnt = 0;
    keep_req = 1'b1;
    reqValid = 4'b1111;
    k = 0;
    while (grant_q.size() < 8 && k < 200) begin step(); k++; end
    keep_req = 1'b0;
    reqValid = '0;
    k = 0;
    while (busy && k < 40) begin step(); k++; end
    while (grant_q.size() < 8) grant_q.push_back(-1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (grant_q[i] != i % 4) begin failures++; $display("FAIL rr_grant%0d got=%0d exp=%0d", i, grant_q[i], i % 4); end
    end
    checks++; if (bad_gnt != 0) begin failures++; $display("FAIL rr_ready_shape got=%0d bad pulses exp=0", bad_gnt); end
  endtask

  task automatic test_back_to_back();
    int k;
    clear_logs();
    bad_gnt = 0;
    respReady = 1'b0;
    reqIn1[2] = 16'h4B48; reqIn2[2] = 16'h47D5; reqValid = 4'b0100;
    k = 0;
    while (rise_q.size() == 0 && k < 30) begin step(); k++; end
    reqIn1[0] = 16'h3C00; reqIn2[0] = 16'h3C00; reqValid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (respValid !== 1'b1 || respId !== 2'd2 || respOut !== 16'h5721 || respErr !== 1'b0 || respStatusFlags !== 5'b00001) begin
        failures++;
        $display("FAIL hold_c%0d got=v%b id%0d %h err%b sf%b exp=v1 id2 5721 err0 sf00001", i, respValid, respId, respOut, respErr, respStatusFlags);
      end
    end
    checks++; if (grant_q.size() != 1) begin failures++; $display("FAIL hold_no_grant got=%0d grants exp=1", grant_q.size()); end
    respReady = 1'b1;
    wait_resps(2, 40, "b2b");
    checks++; if (grant_q[1] != 0 || gcyc_q[1] != resp_q[0].cyc + 1) begin failures++; $display("FAIL b2b_regrant got=lane%0d cyc%0d exp=lane0 cyc%0d", grant_q[1], gcyc_q[1], resp_q[0].cyc + 1); end
    checks++; if (resp_q[1].id != 0 || resp_q[1].out !== 16'h3C00) begin failures++; $display("FAIL b2b_result got=id%0d %h exp=id0 3C00", resp_q[1].id, resp_q[1].out); end
    checks++; if (bad_gnt != 0) begin failures++; $display("FAIL b2b_ready_shape got=%0d exp=0", bad_gnt); end
  endtask

  task automatic test_watchdog();
    int k;
    step();
    clear_logs();
    stub_dead = 1'b1;
    reqIn1[3] = 16'h3C00; reqIn2[3] = 16'h3C00; reqValid = 4'b1000;
    k = 0;
    while (rise_q.size() == 0 && k < 120) begin step(); k++; end
    while (rise_q.size() == 0) rise_q.push_back(-1000);
    stub_dead = 1'b0;
    wait_resps(1, 5, "wd");
    checks++; if (rise_q[0] - start_q[0] != TIMEOUT + 1) begin failures++; $display("FAIL wd_latency got=%0d exp=%0d", rise_q[0] - start_q[0], TIMEOUT + 1); end
    checks++; if (resp_q[0].out !== 16'h7E00 || resp_q[0].err !== 1'b1 || resp_q[0].id != 3) begin failures++; $display("FAIL wd_abort got=%h err%b id%0d exp=7E00 err1 id3", resp_q[0].out, resp_q[0].err, resp_q[0].id); end
    checks++; if (resp_q[0].cc !== 4'h0 || resp_q[0].sf !== 5'h00) begin failures++; $display("FAIL wd_flags got=cc%b sf%b exp=0000 00000", resp_q[0].cc, resp_q[0].sf); end
    reqIn1[0] = 16'h3C00; reqIn2[0] = 16'h3C00; reqValid = 4'b0001;
    wait_resps(2, 40, "wd_next");
    checks++; if (resp_q[1].out !== 16'h3C00 || resp_q[1].err !== 1'b0 || resp_q[1].id != 0) begin failures++; $display("FAIL wd_next got=%h err%b id%0d exp=3C00 err0 id0", resp_q[1].out, resp_q[1].err, resp_q[1].id); end
  endtask

  task automatic test_reset_mid_op();
    int k;
    step();
    clear_logs();
    stub_dead = 1'b1;
    reqIn1[1] = 16'h4A00; reqIn2[1] = 16'h4880; reqValid = 4'b0010;
    k = 0;
    while (start_q.size() == 0 && k < 20) begin step(); k++; end
    repeat (3) step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    reset = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || respValid !== 1'b0) begin failures++; $display("FAIL mid_reset got=busy%b v%b exp=busy0 v0", busy, respValid); end
    reset = 1'b0;
    stub_dead = 1'b0;
    reqIn1[2] = 16'h3C00; reqIn2[2] = 16'h3C00; reqValid = 4'b0100;
    wait_resps(1, 40, "mid");
    repeat (10) step();
    checks++; if (resp_q.size() != 1) begin failures++; $display("FAIL mid_resp_count got=%0d exp=1", resp_q.size()); end
    checks++; if (resp_q[0].id != 2 || resp_q[0].out !== 16'h3C00 || resp_q[0].err !== 1'b0) begin failures++; $display("FAIL mid_fresh got=id%0d %h err%b exp=id2 3C00 err0", resp_q[0].id, resp_q[0].out, resp_q[0].err); end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; bad_gnt = 0;
    prev_gnt = '0; prev_rv = 1'b0; keep_req = 1'b0; stub_dead = 1'b0;
    reset = 1'b1; reqValid = '0; respReady = 1'b1;
    reqIn1 = '0; reqIn2 = '0;
    test_reset();
    test_single();
    test_two_lanes();
    test_fairness();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
